// File: rtl/ether_tx.sv
// RMII transmit framer: preamble, SFD, payload passthrough, then a fixed
// inter-packet gap before the next frame may start.
module ether_tx #(
  parameter int N          = 2,
  parameter int PRE_SYMS   = 64/N-1,
  parameter int IPG_CYCLES = 96/N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [N-1:0] axiid,
  output logic         axiir,
  output logic         txen,
  output logic [N-1:0] txd
);

  // 0x55 / 0xD5 sent LSB-first: every symbol of 0x55 is ..0101, SFD sets the top bit
  localparam logic [N-1:0] PRE_SYM  = {(N/2){2'b01}};
  localparam logic [N-1:0] SFD_SYM  = PRE_SYM | (N'(1) << (N-1));
  localparam logic [5:0]   PRE_LAST = 6'(PRE_SYMS);
  localparam logic [5:0]   IPG_LAST = 6'(IPG_CYCLES-1);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, IPG} state_t;

  state_t         state, state_n;
  logic [5:0]     count, count_n;
  logic           txen_n, axiir_n;
  logic [N-1:0]   txd_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      txen  <= 1'b0;
      txd   <= '0;
      axiir <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      txen  <= txen_n;
      txd   <= txd_n;
      axiir <= axiir_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count + 6'd1;
    txen_n  = txen;
    txd_n   = txd;
    axiir_n = axiir;
    case (state)
      IDLE: begin
        count_n = '0;
        txen_n  = 1'b0;
        txd_n   = '0;
        axiir_n = 1'b0;
        if (axiiv) begin
          state_n = PRE;
          count_n = 6'd1;
          txen_n  = 1'b1;
          txd_n   = PRE_SYM;
        end
      end
      PRE: begin
        // a source that drops valid before SFD aborts the frame outright
        if (!axiiv) begin
          state_n = IPG;
          count_n = '0;
          txen_n  = 1'b0;
          txd_n   = '0;
        end else if (count == PRE_LAST) begin
          state_n = SFD;
          count_n = '0;
          txd_n   = SFD_SYM;
          axiir_n = 1'b1;
        end
      end
      SFD, DATA: begin
        count_n = '0;
        if (axiiv) begin
          state_n = DATA;
          txd_n   = axiid;
        end else begin
          state_n = IPG;
          txen_n  = 1'b0;
          txd_n   = '0;
          axiir_n = 1'b0;
        end
      end
      IPG: begin
        txen_n  = 1'b0;
        txd_n   = '0;
        axiir_n = 1'b0;
        if (count == IPG_LAST) begin
          state_n = IDLE;
          count_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
        txen_n  = 1'b0;
        txd_n   = '0;
        axiir_n = 1'b0;
      end
    endcase
  end

endmodule
